// File: rtl/inst_rom_loader.sv
// Instruction memory responder with a byte-serial program loader.
// Answers core fetches combinationally while running; while loading, it
// assembles big-endian bytes into 32-bit words and writes them in order.
module inst_rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [31:0]           inst,
  input  logic                  load_start,
  input  logic                  run_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  core_hold,
  output logic [DEPTH_LOG2:0]   words_loaded,
  output logic                  load_ovf,
  output logic                  addr_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]            state;
  logic [1:0]            byte_cnt;
  // Only the upper three lanes are ever buffered; the fourth byte goes
  // straight into the word being written.
  logic [23:0]           word_buf;
  logic [31:0]           word_next;
  logic                  accept;
  logic                  word_done;
  logic                  arr_full;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_aligned;
  logic                  rd_in_range;

  logic [31:0] mem [DEPTH];

  assign accept    = (state == ST_LOAD) && load_valid && !load_start;
  assign word_done = accept && ((byte_cnt == 2'd3) || load_last);
  assign arr_full  = words_loaded[DEPTH_LOG2];
  assign wr_en     = word_done && !arr_full;
  assign wr_idx    = words_loaded[DEPTH_LOG2-1:0];

  assign load_ready = (state == ST_LOAD);
  assign core_hold  = (state != ST_RUN);

  // Merge the incoming byte into its lane; lanes below it are zero, which
  // also provides the padding for a short final word.
  always_comb begin
    word_next = '0;
    case (byte_cnt)
      2'd0:    word_next = {load_byte, 24'h000000};
      2'd1:    word_next = {word_buf[23:16], load_byte, 16'h0000};
      2'd2:    word_next = {word_buf[23:8], load_byte, 8'h00};
      default: word_next = {word_buf, load_byte};
    endcase
  end

  // Control state machine, byte assembly and load bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      word_buf     <= '0;
      words_loaded <= '0;
      load_ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state        <= ST_LOAD;
            byte_cnt     <= '0;
            word_buf     <= '0;
            words_loaded <= '0;
            load_ovf     <= 1'b0;
          end else if (run_start) begin
            state <= ST_RUN;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            byte_cnt     <= '0;
            word_buf     <= '0;
            words_loaded <= '0;
            load_ovf     <= 1'b0;
          end else if (accept) begin
            word_buf <= word_next[31:8];
            if (word_done) begin
              if (arr_full) begin
                load_ovf <= 1'b1;
              end else begin
                words_loaded <= words_loaded + 1'b1;
              end
            end
            if (load_last) begin
              state    <= ST_RUN;
              byte_cnt <= '0;
              word_buf <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (load_start) begin
            state        <= ST_LOAD;
            byte_cnt     <= '0;
            word_buf     <= '0;
            words_loaded <= '0;
            load_ovf     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= word_next;
    end
  end

  assign rd_idx      = inst_addr[DEPTH_LOG2+1:2];
  assign rd_aligned  = (inst_addr[1:0] == 2'b00);
  assign rd_in_range = ((inst_addr >> (DEPTH_LOG2 + 2)) == '0);

  // Same-cycle fetch response; bad addresses return a NOP and flag an error.
  always_comb begin
    inst     = '0;
    addr_err = 1'b0;
    if ((state == ST_RUN) && ce) begin
      if (rd_aligned && rd_in_range) begin
        inst = mem[rd_idx];
      end else begin
        addr_err = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a default-depth instance and a
// four-word instance share one stimulus stream; fetch results are checked
// against a queue of expected responses built from a behavioural model.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] inst_addr;
  logic        load_start, run_start, load_valid, load_last;
  logic [7:0]  load_byte;

  logic [31:0] inst_b, inst_s;
  logic        ready_b, ready_s, hold_b, hold_s, ovf_b, ovf_s, err_b, err_s;
  logic [10:0] wl_b;
  logic [2:0]  wl_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state (index 0 = default depth, 1 = four-word instance)
  int          m_state;  // 0 idle, 1 load, 2 run
  int          m_bc;
  logic [31:0] m_buf;
  int          m_wl  [2];
  bit          m_ovf [2];
  logic [31:0] mem_b [1024];
  logic [31:0] mem_s [4];
  int          dlog  [2] = '{10, 2};

  typedef struct {
    string       tag;
    bit          sel;
    logic [31:0] inst;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  inst_rom_loader #(.DEPTH_LOG2(10), .ADDR_W(32)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .inst_addr(inst_addr), .inst(inst_b),
    .load_start(load_start), .run_start(run_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(ready_b),
    .core_hold(hold_b), .words_loaded(wl_b), .load_ovf(ovf_b), .addr_err(err_b)
  );

  inst_rom_loader #(.DEPTH_LOG2(2), .ADDR_W(32)) dut_s (
    .clk(clk), .rst(rst), .ce(ce), .inst_addr(inst_addr), .inst(inst_s),
    .load_start(load_start), .run_start(run_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(ready_s),
    .core_hold(hold_s), .words_loaded(wl_s), .load_ovf(ovf_s), .addr_err(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bc = 0; m_buf = '0;
    m_wl[0] = 0; m_wl[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
  endtask

  task automatic pulse(input bit ls, input bit rs);
    @(negedge clk);
    load_start = ls; run_start = rs;
    @(posedge clk); #1;
    load_start = 1'b0; run_start = 1'b0;
    if (ls) begin
      m_state = 1; m_bc = 0; m_buf = '0;
      m_wl[0] = 0; m_wl[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    end else if (rs && m_state == 0) begin
      m_state = 2;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    m_buf[31 - 8*m_bc -: 8] = b;
    if (m_bc == 3 || last) begin
      for (int d = 0; d < 2; d++) begin
        if (m_wl[d] < (1 << dlog[d])) begin
          if (d == 0) mem_b[m_wl[d]] = m_buf;
          else        mem_s[m_wl[d]] = m_buf;
          m_wl[d]++;
        end else begin
          m_ovf[d] = 1'b1;
        end
      end
      m_buf = '0;
      m_bc  = 0;
      if (last) m_state = 2;
    end else begin
      m_bc++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    @(negedge clk);
    load_valid = 1'b1; load_byte = b; load_last = last;
    @(posedge clk); #1;
    load_valid = 1'b0; load_last = 1'b0;
    if (m_state == 1) model_byte(b, last);
  endtask

  // Push the expected response, apply the fetch, then pop and compare.
  task automatic fetch(input bit sel, input bit c, input logic [31:0] a, input string tag,
                       input bit use_k = 1'b0, input logic [31:0] k = '0);
    exp_t e;
    exp_t got;
    e.tag = tag; e.sel = sel; e.inst = '0; e.err = 1'b0;
    if (m_state == 2 && c) begin
      if (a[1:0] == 2'b00 && (a >> (dlog[sel] + 2)) == 0) begin
        e.inst = sel ? mem_s[a[3:2]] : mem_b[a[11:2]];
      end else begin
        e.err = 1'b1;
      end
    end
    if (use_k) e.inst = k;
    sb.push_back(e);
    @(negedge clk);
    ce = c; inst_addr = a;
    #1;
    got = sb.pop_front();
    chk({got.tag, "_inst"}, got.sel ? inst_s : inst_b, got.inst);
    chk({got.tag, "_err"}, {31'b0, got.sel ? err_s : err_b}, {31'b0, got.err});
  endtask

  task automatic status(input string tag);
    chk({tag, "_hold_b"},  {31'b0, hold_b},  {31'b0, m_state != 2});
    chk({tag, "_ready_b"}, {31'b0, ready_b}, {31'b0, m_state == 1});
    chk({tag, "_wl_b"},    {21'b0, wl_b},    m_wl[0]);
    chk({tag, "_ovf_b"},   {31'b0, ovf_b},   {31'b0, m_ovf[0]});
    chk({tag, "_wl_s"},    {29'b0, wl_s},    m_wl[1]);
    chk({tag, "_ovf_s"},   {31'b0, ovf_s},   {31'b0, m_ovf[1]});
  endtask

  initial begin
    logic [7:0] t1 [8] = '{8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};
    logic [7:0] t2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    rst = 1'b0; ce = 1'b1; inst_addr = '0;
    load_start = 1'b0; run_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_byte = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    status("reset");
    chk("reset_hold_s", {31'b0, hold_s}, 32'd1);
    fetch(0, 1'b1, 32'h0, "reset_fetch");
    @(negedge clk) rst = 1'b1;

    // 1: two full words
    pulse(1'b1, 1'b0);
    status("t1_loading");
    for (int i = 0; i < 8; i++) send_byte(t1[i], i == 7);
    status("t1_run");
    chk("t1_wl_const", {21'b0, wl_b}, 32'd2);
    fetch(0, 1'b1, 32'h0, "t1_w0", 1'b1, 32'h34010001);
    fetch(0, 1'b1, 32'h4, "t1_w1", 1'b1, 32'h34020002);
    fetch(1, 1'b1, 32'h4, "t1_s_w1");

    // 2: short final word is zero-padded
    pulse(1'b1, 1'b0);
    chk("t2_hold_after_start", {31'b0, hold_b}, 32'd1);
    for (int i = 0; i < 5; i++) send_byte(t2[i], i == 4);
    status("t2_run");
    fetch(0, 1'b1, 32'h0, "t2_w0", 1'b1, 32'hAABBCCDD);
    fetch(0, 1'b1, 32'h4, "t2_w1", 1'b1, 32'hEE000000);

    // 3: fetch qualification and address errors
    fetch(0, 1'b0, 32'h4, "t3_ce0");
    fetch(0, 1'b1, 32'h2, "t3_misal");
    fetch(0, 1'b1, 32'h1000, "t3_range");
    fetch(0, 1'b1, 32'hFFC, "t3_top");
    fetch(1, 1'b1, 32'h10, "t3_s_range");

    // 4: overflow on the four-word instance
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i), i == 19);
    status("t4_run");
    chk("t4_ovf_s_const", {31'b0, ovf_s}, 32'd1);
    chk("t4_wl_s_const", {29'b0, wl_s}, 32'd4);
    for (int i = 0; i < 4; i++) fetch(1, 1'b1, 32'(4*i), $sformatf("t4_s_w%0d", i));
    fetch(1, 1'b1, 32'hC, "t4_s_w3k", 1'b1, 32'h1C1D1E1F);
    fetch(0, 1'b1, 32'h10, "t4_b_w4");
    pulse(1'b1, 1'b0);
    status("t4_restart");

    // 5: asynchronous reset part-way through word 3
    for (int i = 0; i < 14; i++) send_byte(8'h80 + 8'(i), 1'b0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    status("t5_async");
    @(negedge clk) rst = 1'b1;
    pulse(1'b0, 1'b1);
    chk("t5_hold_run", {31'b0, hold_b}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch(0, 1'b1, 32'(4*i), $sformatf("t5_b_w%0d", i));
      fetch(1, 1'b1, 32'(4*i), $sformatf("t5_s_w%0d", i));
    end
    fetch(0, 1'b1, 32'h8, "t5_w2k", 1'b1, 32'h88898A8B);

    // 6: load_start beats run_start; reload from RUN holds the core
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    pulse(1'b1, 1'b1);
    status("t6_both");
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), i == 3);
    fetch(0, 1'b1, 32'h0, "t6_w0", 1'b1, 32'hC0C1C2C3);
    pulse(1'b1, 1'b0);
    status("t6_reload");
    fetch(0, 1'b1, 32'h0, "t6_held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
